// File: rtl/spike_rate_decoder_if.sv
// Result channel of the spike-rate decoder: winning class, its count and a tie
// flag, delivered with a valid/ready handshake.
interface spike_rate_decoder_if #(
  parameter int unsigned CLS_W = 4,
  parameter int unsigned CNT_W = 5
);
  logic             valid;
  logic             ready;
  logic [CLS_W-1:0] class_out;
  logic [CNT_W-1:0] class_count;
  logic             tie;

  modport master (output valid, class_out, class_count, tie, input ready);
  modport slave  (input valid, class_out, class_count, tie, output ready);
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts final-layer spikes per class over WINDOW ce-qualified timesteps, then
// scans the counters one class per clock to report the argmax and a tie flag.
module spike_rate_decoder #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned WINDOW      = 16,
  parameter int unsigned CLS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  parameter int unsigned CNT_W       = $clog2(WINDOW + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   start,
  input  logic [NUM_CLASSES-1:0] spike_in,
  output logic                   busy,
  spike_rate_decoder_if.master   res
);

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

  localparam logic [CNT_W-1:0] TS_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [CLS_W-1:0] IDX_LAST = CLS_W'(NUM_CLASSES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0] ts_q;
  logic [CLS_W-1:0] idx_q;
  logic [CNT_W-1:0] best_q, best_d;
  logic [CLS_W-1:0] best_idx_q, best_idx_d;
  logic             tie_scan_q, tie_scan_d;
  logic             busy_q;
  logic             valid_q;
  logic [CLS_W-1:0] class_out_q;
  logic [CNT_W-1:0] class_count_q;
  logic             tie_q;
  logic [CNT_W-1:0] cur_cnt;

  // One comparison step of the argmax scan; strict '>' keeps the lowest index on ties.
  always_comb begin
    cur_cnt    = cnt_q[idx_q];
    best_d     = best_q;
    best_idx_d = best_idx_q;
    tie_scan_d = tie_scan_q;
    if (idx_q == '0 || cur_cnt > best_q) begin
      best_d     = cur_cnt;
      best_idx_d = idx_q;
      tie_scan_d = 1'b0;
    end else if (cur_cnt == best_q) begin
      tie_scan_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
      ts_q          <= '0;
      idx_q         <= '0;
      best_q        <= '0;
      best_idx_q    <= '0;
      tie_scan_q    <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      class_out_q   <= '0;
      class_count_q <= '0;
      tie_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
            ts_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (ce) begin
            for (int unsigned i = 0; i < NUM_CLASSES; i++)
              cnt_q[i] <= cnt_q[i] + CNT_W'(spike_in[i]);
            ts_q <= ts_q + 1'b1;
            if (ts_q == TS_LAST) begin
              idx_q      <= '0;
              best_q     <= '0;
              best_idx_q <= '0;
              tie_scan_q <= 1'b0;
              state_q    <= SCAN;
            end
          end
        end
        SCAN: begin
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
          tie_scan_q <= tie_scan_d;
          idx_q      <= idx_q + 1'b1;
          // The last class's step feeds the result registers directly, saving a cycle.
          if (idx_q == IDX_LAST) begin
            class_out_q   <= best_idx_d;
            class_count_q <= best_d;
            tie_q         <= tie_scan_d;
            valid_q       <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= DONE;
          end
        end
        DONE: begin
          if (res.ready) begin
            valid_q <= 1'b0;
            if (start) begin
              for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
              ts_q    <= '0;
              busy_q  <= 1'b1;
              state_q <= ACCUM;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign res.valid       = valid_q;
  assign res.class_out   = class_out_q;
  assign res.class_count = class_count_q;
  assign res.tie         = tie_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: directed scenarios plus random traffic, all
// compared every cycle against a transaction-level spike-count model.
module tb_spike_rate_decoder;
  localparam int NC    = 10;
  localparam int WIN   = 16;
  localparam int CLS_W = 4;
  localparam int CNT_W = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [NC-1:0] spike_in = '0;
  logic          busy;

  spike_rate_decoder_if #(.CLS_W(CLS_W), .CNT_W(CNT_W)) res ();
  assign res.ready = ready;

  spike_rate_decoder #(
    .NUM_CLASSES(NC),
    .WINDOW(WIN),
    .CLS_W(CLS_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ce(ce),
    .start(start),
    .spike_in(spike_in),
    .busy(busy),
    .res(res)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 collecting, 2 argmax pending, 3 result held.
  int m_phase, m_samples, m_scan_left;
  int m_cnt [NC];
  int e_busy, e_valid, e_cls, e_count, e_tie;

  task automatic model_reset();
    m_phase = 0; m_samples = 0; m_scan_left = 0;
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    e_busy = 0; e_valid = 0; e_cls = 0; e_count = 0; e_tie = 0;
  endtask

  task automatic model_open_window();
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    m_samples = 0;
    m_phase = 1;
  endtask

  task automatic model_argmax();
    int mx, nmx;
    mx = 0;
    for (int i = 0; i < NC; i++) if (m_cnt[i] > mx) mx = m_cnt[i];
    nmx = 0;
    e_cls = -1;
    for (int i = 0; i < NC; i++)
      if (m_cnt[i] == mx) begin
        nmx++;
        if (e_cls < 0) e_cls = i;
      end
    e_count = mx;
    e_tie = (nmx > 1) ? 1 : 0;
  endtask

  task automatic model_step();
    case (m_phase)
      0: if (start) model_open_window();
      1: if (ce) begin
           for (int i = 0; i < NC; i++) m_cnt[i] += int'(spike_in[i]);
           m_samples++;
           if (m_samples == WIN) begin
             m_phase = 2;
             m_scan_left = NC;
           end
         end
      2: begin
           m_scan_left--;
           if (m_scan_left == 0) begin
             model_argmax();
             m_phase = 3;
           end
         end
      default: if (ready) begin
                 if (start) model_open_window();
                 else m_phase = 0;
               end
    endcase
    e_busy  = (m_phase == 1 || m_phase == 2) ? 1 : 0;
    e_valid = (m_phase == 3) ? 1 : 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("busy", busy, e_busy);
      chk("valid", res.valid, e_valid);
      chk("class_out", res.class_out, e_cls);
      chk("class_count", res.class_count, e_count);
      chk("tie", res.tie, e_tie);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!res.valid && n < 200) begin
      tick();
      n++;
    end
    chk("valid_timeout", res.valid, 1);
  endtask

  task automatic accept();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  int n_lat, n_tmp;
  logic [NC-1:0] vec;

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 5; i++) begin
      tick();
      ce = 1'($urandom); start = 1'($urandom); ready = 1'($urandom);
      spike_in = NC'($urandom);
    end
    chk("rst_busy", busy, 0);
    chk("rst_valid", res.valid, 0);
    chk("rst_cls", res.class_out, 0);
    chk("rst_count", res.class_count, 0);
    chk("rst_tie", res.tie, 0);
    start = 1'b0; ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("idle_busy", busy, 0);
    chk("idle_valid", res.valid, 0);

    // Single winner on class 3
    ce = 1'b1; spike_in = 10'b0000001000;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(n_lat);
    chk("single_latency", n_lat, 26);
    chk("single_cls", res.class_out, 3);
    chk("single_count", res.class_count, 16);
    chk("single_tie", res.tie, 0);
    chk("model_single_cls", e_cls, 3);
    accept();

    // Tie between classes 2 and 7 at 5 spikes
    spike_in = '0;
    start = 1'b1; tick(); start = 1'b0;
    for (int t = 0; t < WIN; t++) begin
      if (t < 5) spike_in = 10'b0000000100;
      else if (t < 10) spike_in = 10'b0010000000;
      else if (t < 13) spike_in = 10'b0000010000;
      else spike_in = '0;
      tick();
    end
    spike_in = '0;
    wait_valid(n_tmp);
    chk("tie_cls", res.class_out, 2);
    chk("tie_count", res.class_count, 5);
    chk("tie_flag", res.tie, 1);
    chk("model_tie_flag", e_tie, 1);
    accept();

    // ce gating: class 1 only on ce=1, class 9 only on ce=0
    start = 1'b1; tick(); start = 1'b0;
    for (int t = 0; t < 2 * WIN; t++) begin
      ce = 1'(t % 2);
      spike_in = ce ? 10'b0000000010 : 10'b1000000000;
      tick();
    end
    ce = 1'b1; spike_in = '0;
    wait_valid(n_tmp);
    chk("gate_latency", 2 * WIN + n_tmp, 42);
    chk("gate_cls", res.class_out, 1);
    chk("gate_count", res.class_count, 16);
    chk("gate_tie", res.tie, 0);

    // Backpressure: result held, start ignored without ready
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      tick();
      chk("hold_valid", res.valid, 1);
      chk("hold_cls", res.class_out, 1);
      chk("hold_count", res.class_count, 16);
    end
    ready = 1'b1; start = 1'b1; ce = 1'b1; spike_in = NC'($urandom);
    tick();
    ready = 1'b0; start = 1'b0;
    chk("restart_valid", res.valid, 0);
    chk("restart_busy", busy, 1);
    for (int t = 0; t < WIN; t++) begin
      spike_in = NC'($urandom);
      tick();
    end
    wait_valid(n_tmp);
    accept();

    // Mid-window reset, then a zero-spike window
    start = 1'b1; tick(); start = 1'b0;
    for (int t = 0; t < 8; t++) begin
      spike_in = NC'($urandom);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", res.valid, 0);
    chk("midrst_cls", res.class_out, 0);
    chk("midrst_count", res.class_count, 0);
    chk("midrst_tie", res.tie, 0);
    tick();
    rst_n = 1'b1;
    tick();
    spike_in = '0; ce = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(n_tmp);
    chk("zero_cls", res.class_out, 0);
    chk("zero_count", res.class_count, 0);
    chk("zero_tie", res.tie, 1);
    accept();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      ce    = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 7) == 0);
      ready = ($urandom_range(0, 2) == 0);
      vec   = NC'($urandom) & NC'($urandom);
      spike_in = vec;
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Consumer of the classifier network's output spike vector (final layer, one bit per class).
- Counts the spikes on each class over a fixed window of network timesteps, then picks the class with the most spikes (argmax).
- Delivers the winning class index, its spike count and a tie flag over a valid/ready handshake. Sits between the network core and the host/readout logic.

Parameters:
- NUM_CLASSES, 10, number of class spike lines (width of the final-layer spike output).
- WINDOW, 16, number of ce-qualified timesteps accumulated per inference (>=1).
- CLS_W, $clog2(NUM_CLASSES), width of the class index.
- CNT_W, $clog2(WINDOW+1), width of each per-class counter (never overflows).

Ports:
- clk  in  1  Single clock.
- rst_n  in  1  Asynchronous active-low reset.
- ce  in  1  Timestep strobe, same signal that advances the network; spikes are sampled only when ce=1.
- start  in  1  Begin a new accumulation window; honoured only in IDLE, or in DONE on the cycle the result is accepted.
- spike_in  in  NUM_CLASSES  Spike vector from the network's final layer.
- busy  out  1  High in ACCUM and SCAN.
- valid  out  1  Result available.
- ready  in  1  Consumer accepts the result when valid&&ready.
- class_out  out  CLS_W  Winning class index.
- class_count  out  CNT_W  Spike count of the winning class.
- tie  out  1  Another class has the same maximal count.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All counters, the timestep counter and the scan index are cleared.
  - busy=0, valid=0, class_out=0, class_count=0, tie=0.
  - Applies immediately in any state, including mid-window; any partial result is discarded.
- IDLE:
  - start=1 → clear all class counters and the timestep counter, go to ACCUM.
  - start=0 → stay in IDLE.
- ACCUM:
  - Each edge with ce=1: for every class i, cnt[i] += spike_in[i]; the timestep counter increments.
  - Each edge with ce=0: no change; spikes are ignored.
  - The edge that takes the WINDOW-th ce sample moves to SCAN with scan index=0, best=0, best_idx=0, tie=0.
  - start is ignored while in ACCUM.
- SCAN: one class per clock, independent of ce. At index i:
  - cnt[i] > best, or i==0 → best=cnt[i], best_idx=i, tie=0.
  - i>0 and cnt[i]==best → tie=1.
  - Otherwise no change.
  - Strict greater-than means the lowest index wins ties.
  - After index NUM_CLASSES-1 → DONE.
- DONE:
  - valid=1; class_out, class_count and tie are held stable until the handshake.
  - valid&&ready → valid drops on the next edge.
  - If start=1 on the same edge as the handshake → go to ACCUM with counters cleared; otherwise → IDLE.
  - start without ready is ignored.
- Latency: start sampled at edge k. With ce held high, valid is high after edge k+WINDOW+NUM_CLASSES, which is 26 cycles for the defaults.
- Outputs are registered: class_out, class_count and tie change only on entry to DONE or on reset.
- Zero-spike window: class_out=0, class_count=0, tie=1 (when NUM_CLASSES>1).
- Counter width: a count of exactly WINDOW is representable, so no saturation logic is required.

Test Plan:
- Reset check: hold rst_n=0 with random inputs → busy=0, valid=0, class_out=0, class_count=0, tie=0. Release reset with start=0 → outputs stay 0.
- Single winner: ce=1, spike_in=10'b0000001000 every cycle, pulse start → busy=1 for 26 cycles, then valid=1 with class_out=3, class_count=16, tie=0.
- Tie: over 16 timesteps, class 2 and class 7 each spike 5 times, class 4 spikes 3 times, others 0 → class_out=2, class_count=5, tie=1.
- ce gating: ce toggles 1/0. Class 1 spikes only on ce=1 cycles; class 9 spikes only on ce=0 cycles → class_out=1, class_count=16, tie=0; valid after 32+10 cycles.
- Backpressure and restart:
  - Hold ready=0 for 20 cycles after valid → valid and all outputs stay constant.
  - start pulses during this hold are ignored.
  - Then ready=1 together with start=1 → valid=0 and busy=1 on the next cycle; the new window completes normally.
- Mid-window reset and zero-spike window:
  - Assert rst_n=0 after 8 timesteps → immediate busy=0 with outputs zero.
  - Next window with spike_in=0 → class_out=0, class_count=0, tie=1.
